// File: rtl/perceptron_controller_pkg.sv
// Shared types and constants for the perceptron training controller.
package perceptron_pkg;
  localparam int EPOCH_W_DEF = 8;
  localparam int NUM_SAMPLES = 200;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EVAL, S_EPOCH_END, S_TEST, S_DONE
  } pctrl_state_t;
endpackage

// File: rtl/perceptron_controller_if.sv
// Controller <-> datapath/top bundle: start/abort, datapath status, control strobes, run status.
interface perceptron_controller_if
  import perceptron_pkg::*;
#(
  parameter int EPOCH_W = EPOCH_W_DEF
);
  logic start, abort;
  logic cout, flag, update;
  logic initCounter, initW1, initW2, initB, initFlag;
  logic setFlag, ldW1, ldW2, ldB;
  logic enableCount, enableTest;
  logic ready, done, converged, timeout;
  logic [EPOCH_W-1:0] epochs;

  modport master (
    input  start, abort, cout, flag, update,
    output initCounter, initW1, initW2, initB, initFlag,
    output setFlag, ldW1, ldW2, ldB, enableCount, enableTest,
    output ready, done, converged, timeout, epochs
  );

  modport slave (
    output start, abort, cout, flag, update,
    input  initCounter, initW1, initW2, initB, initFlag,
    input  setFlag, ldW1, ldW2, ldB, enableCount, enableTest,
    input  ready, done, converged, timeout, epochs
  );
endinterface

// File: rtl/perceptron_controller_epoch_counter.sv
// Saturating epoch counter; at_limit flags that the next increment reaches LIMIT.
module epoch_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);
  logic [W:0] cnt_p1;

  assign cnt_p1   = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign at_limit = (cnt_p1 >= (W+1)'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (inc && !(&cnt))   cnt <= cnt_p1[W-1:0];
  end
endmodule

// File: rtl/perceptron_controller.sv
// Sequencing FSM for the perceptron training datapath.
// Build option: define PCTRL_EPOCH_LIMIT_EN to stop training after MAX_EPOCHS epochs.
module perceptron_controller
  import perceptron_pkg::*;
#(
  parameter int MAX_EPOCHS = 64,
  parameter int EPOCH_W    = EPOCH_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  perceptron_controller_if.master bus
);
  pctrl_state_t st, nxt;
  logic [EPOCH_W-1:0] ep_q;
  logic at_limit, lim_hit;
  logic st_clr, ep_inc, set_conv, set_tmo;
  logic conv_q, tmo_q;

`ifdef PCTRL_EPOCH_LIMIT_EN
  assign lim_hit = at_limit;
`else
  logic unused_at_limit;
  assign unused_at_limit = at_limit;
  assign lim_hit = 1'b0;
`endif

  epoch_counter #(.W(EPOCH_W), .LIMIT(MAX_EPOCHS)) u_epoch (
    .clk(clk), .rst(rst), .clr(st_clr), .inc(ep_inc), .cnt(ep_q), .at_limit(at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= S_IDLE;
    else      st <= nxt;
  end

  // abort wins over everything and suppresses all strobes and status updates
  always_comb begin
    nxt             = st;
    bus.initCounter = 1'b0;
    bus.initW1      = 1'b0;
    bus.initW2      = 1'b0;
    bus.initB       = 1'b0;
    bus.initFlag    = 1'b0;
    bus.setFlag     = 1'b0;
    bus.ldW1        = 1'b0;
    bus.ldW2        = 1'b0;
    bus.ldB         = 1'b0;
    bus.enableCount = 1'b0;
    bus.enableTest  = 1'b0;
    bus.done        = 1'b0;
    st_clr          = 1'b0;
    ep_inc          = 1'b0;
    set_conv        = 1'b0;
    set_tmo         = 1'b0;
    if (bus.abort) begin
      nxt = S_IDLE;
    end else begin
      case (st)
        S_IDLE: if (bus.start) nxt = S_INIT;
        S_INIT: begin
          bus.initCounter = 1'b1;
          bus.initW1      = 1'b1;
          bus.initW2      = 1'b1;
          bus.initB       = 1'b1;
          bus.initFlag    = 1'b1;
          st_clr          = 1'b1;
          nxt             = S_EVAL;
        end
        S_EVAL: begin
          bus.enableCount = 1'b1;
          bus.ldW1        = bus.update;
          bus.ldW2        = bus.update;
          bus.ldB         = bus.update;
          bus.setFlag     = bus.update;
          if (bus.cout) nxt = S_EPOCH_END;
        end
        S_EPOCH_END: begin
          ep_inc = 1'b1;
          if (!bus.flag) begin
            set_conv = 1'b1;
            nxt      = S_TEST;
          end else if (lim_hit) begin
            set_tmo = 1'b1;
            nxt     = S_TEST;
          end else begin
            bus.initFlag    = 1'b1;
            bus.initCounter = 1'b1;
            nxt             = S_EVAL;
          end
        end
        S_TEST: begin
          bus.enableTest = 1'b1;
          nxt            = S_DONE;
        end
        S_DONE: begin
          bus.done = 1'b1;
          nxt      = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else if (st_clr) begin
      conv_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      if (set_conv) conv_q <= 1'b1;
      if (set_tmo)  tmo_q  <= 1'b1;
    end
  end

  assign bus.ready     = (st == S_IDLE);
  assign bus.converged = conv_q;
  assign bus.timeout   = tmo_q;
  assign bus.epochs    = ep_q;
endmodule

// File: doc/perceptron_controller.md
# perceptron_controller

Sequencing FSM for the perceptron training datapath. On `start` it initialises the counter, weights, bias and flag, then sweeps the 200 training samples once per cycle, updating weights when `update` indicates a misclassification. It repeats epochs until one completes with no update, or until an epoch limit is reached, then pulses the test unit. It drives every control input of the datapath and reports status to the top level.

## Interface
- `MAX_EPOCHS`, 64: epoch limit, used only when the limit feature is compiled in.
- `EPOCH_W`, 8: width of the epoch counter. Must satisfy 2^EPOCH_W > MAX_EPOCHS.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin training. Sampled only in IDLE.
- `abort`  in  1  synchronous abort. Sends the FSM to IDLE from any state.
- `cout`  in  1  datapath counter is at the last sample.
- `flag`  in  1  registered "an update occurred this epoch" flag.
- `update`  in  1  current sample is misclassified (combinational from the datapath).
- `initCounter`, `initW1`, `initW2`, `initB`, `initFlag`  out  1 each  datapath clears.
- `setFlag`, `ldW1`, `ldW2`, `ldB`  out  1 each  datapath flag set and weight/bias loads.
- `enableCount`, `enableTest`  out  1 each  counter advance and test-unit strobe.
- `ready`  out  1  FSM is in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `converged`  out  1  the last run ended on an update-free epoch.
- `timeout`  out  1  the last run hit `MAX_EPOCHS`.
- `epochs`  out  EPOCH_W  number of epochs completed in the last or current run.

## Operation
- **States:** IDLE, INIT, EVAL, EPOCH_END, TEST, DONE.
- **IDLE:** `ready`=1. If `start`=1 and `abort`=0, go to INIT.
- **INIT (1 cycle):**
  - Assert `initCounter`, `initW1`, `initW2`, `initB` and `initFlag`.
  - Clear `epochs`, `converged` and `timeout`.
  - Go to EVAL.
- **EVAL (one sample per cycle):**
  - `enableCount`=1 every cycle.
  - `ldW1`, `ldW2`, `ldB` and `setFlag` each equal `update`. This is a Mealy path: the weights load from the current-sample datapath result on the same edge that advances the counter.
  - If `cout`=1, go to EPOCH_END. Otherwise stay in EVAL.
- **EPOCH_END (1 cycle):** `epochs` increments, saturating at all-ones. Then, in priority order:
  - `flag`=0: set `converged`=1 and go to TEST.
  - Else, if the limit feature is enabled and `epochs`+1 ≥ `MAX_EPOCHS`: set `timeout`=1 and go to TEST.
  - Else: assert `initFlag` and `initCounter`, and go to EVAL.
- **TEST (1 cycle):** `enableTest`=1. Go to DONE.
- **DONE (1 cycle):** `done`=1. Go to IDLE.
- **Boundary rules:**
  - All datapath controls not listed for a state are 0.
  - `abort` has priority over every transition and asserts no load, init, set or enable that cycle.
  - `start` while not in IDLE is ignored.
  - `start` and `abort` together in IDLE: remain in IDLE.
  - `converged`, `timeout` and `epochs` hold their values until the next INIT. `abort` does not clear them.

## Timing
- **Reset values:** state is IDLE. `ready`=1. All other outputs are 0, and `epochs`=0.
- **Start-to-done latency:**
  - `start` is sampled at edge 0.
  - INIT occupies cycle 1. EVAL occupies cycles 2–201.
  - EPOCH_END is cycle 202, TEST is cycle 203, and DONE is cycle 204 for a one-epoch convergent run.
  - Each additional epoch adds 201 cycles.
- **Flag timing:** `setFlag` is registered by the datapath. `flag` reflects the whole epoch when the FSM enters EPOCH_END.
- **Registered vs combinational outputs:**
  - `converged`, `timeout` and `epochs` are registered.
  - All control strobes are decoded from state (plus `update` in EVAL).

## Configuration
- `PCTRL_EPOCH_LIMIT_EN` defined:
  - The `MAX_EPOCHS` check is active.
  - `timeout` can assert.
- `PCTRL_EPOCH_LIMIT_EN` undefined:
  - Training runs until convergence.
  - `timeout` is tied to 0.
  - `epochs` still counts and saturates.

## Structure
- `perceptron_pkg` holds:
  - the `pctrl_state_t` enum;
  - the default `EPOCH_W` constant;
  - the `NUM_SAMPLES`=200 constant, used by benches only.
- One sub-module, `epoch_counter`: a saturating counter with clear, increment and a limit-compare output. It is instantiated once.
- The FSM, output decode and status registers live in `perceptron_controller`.

## Test plan
- **Reset mid-EVAL:** pull `rst` low at cycle 50. All strobes drop immediately, and after release the FSM is in IDLE with `ready`=1 and `epochs`=0.
- **Separable set with no misclassifications:** stub `update`=0. `done` pulses at cycle 204 with `converged`=1, `epochs`=1, and zero `ld*` pulses.
- **Set converging in epoch 3:** stub `update`=1 on samples 5 and 17 in epochs 1–2, 0 thereafter. Expect:
  - four `ldW1` pulses in total;
  - `initFlag` asserted twice from EPOCH_END;
  - `done` at cycle 606 with `epochs`=3.
- **Limit enabled, non-separable:** with `MAX_EPOCHS`=4 and `update`=1 always, expect `timeout`=1, `converged`=0, `epochs`=4, and exactly one `enableTest`. With the macro undefined, the run continues past epoch 4.
- **Abort at cycle 100:** the FSM is in IDLE on the next cycle with no `enableTest`; a new `start` then runs normally from INIT.
- **Stray and contending inputs:**
  - `start` held high through a whole run: exactly one INIT per run, and a restart occurs only after DONE→IDLE.
  - `start`+`abort` in IDLE: the FSM stays in IDLE.
